// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg: register map, bit indices, FSM states and config record for filter_sharpening_ctrl
package filter_ctrl_pkg;
  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_STRENGTH = 3'd1;
  localparam logic [2:0] ADR_EXP_W    = 3'd2;
  localparam logic [2:0] ADR_EXP_H    = 3'd3;
  localparam logic [2:0] ADR_STATUS   = 3'd4;
  localparam logic [2:0] ADR_MEAS     = 3'd5;
  localparam logic [2:0] ADR_FCNT     = 3'd6;
  localparam int CTRL_BYPASS   = 0;
  localparam int CTRL_ENABLE   = 1;
  localparam int CTRL_IRQ_CLR  = 2;
  localparam int CTRL_ERR_CLR  = 3;
  localparam int CTRL_FCNT_CLR = 4;
  localparam int ST_IRQ   = 0;
  localparam int ST_ERR_W = 1;
  localparam int ST_ERR_H = 2;
  localparam int ST_BUSY  = 3;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_LINE, S_HBLANK, S_FEND} state_t;
  typedef struct packed {
    logic        bypass;
    logic [7:0]  strength;
    logic [31:0] exp_w;
    logic [31:0] exp_h;
  } cfg_t;
  localparam cfg_t CFG_RST = '{bypass: 1'b1, strength: 8'd0, exp_w: 32'd0, exp_h: 32'd0};
endpackage

// File: rtl/video_sync_meas.sv
// video_sync_meas: registered vs/hs edge detection and saturating pixel/line counters
module video_sync_meas #(
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 2048,
  parameter int PW = $clog2(LINE_SIZE_MAX + 1),
  parameter int LW = $clog2(FRAME_LINES_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          de_i,
  input  logic          hs_i,
  input  logic          vs_i,
  input  logic          pix_en,
  input  logic          pix_clr,
  input  logic          line_inc,
  input  logic          line_clr,
  output logic          line_end,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_end,
  output logic          pix_ovf,
  output logic          line_ovf,
  output logic [PW-1:0] pix_cnt,
  output logic [LW-1:0] line_cnt
);
  logic vs_q, vs_qq, hs_q, hs_qq, de_q, pix_sat, line_sat;
  assign pix_sat     = pix_cnt == PW'(LINE_SIZE_MAX);
  assign line_sat    = line_cnt == LW'(FRAME_LINES_MAX);
  assign line_end    = hs_q & ~hs_qq;
  assign line_start  = ~hs_q & hs_qq;
  assign frame_start = vs_q & ~vs_qq;
  assign frame_end   = ~vs_q & vs_qq;
  assign pix_ovf     = pix_en & de_q & pix_sat & ~pix_clr;
  assign line_ovf    = line_inc & line_sat & ~line_clr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {vs_q, vs_qq, hs_q, hs_qq, de_q} <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      {vs_qq, vs_q} <= {vs_q, vs_i};
      {hs_qq, hs_q} <= {hs_q, hs_i};
      de_q     <= de_i;
      pix_cnt  <= pix_clr ? '0 : (pix_en && de_q && !pix_sat) ? pix_cnt + 1'b1 : pix_cnt;
      line_cnt <= line_clr ? '0 : (line_inc && !line_sat) ? line_cnt + 1'b1 : line_cnt;
    end
endmodule

// File: rtl/filter_sharpening_ctrl.sv
// filter_sharpening_ctrl: frame-synchronous shadow/commit register file and video geometry checker.
// Optional frame counter at address 6 when FILTER_SHARPENING_CTRL_FCNT_EN is defined.
module filter_sharpening_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int LINE_SIZE_MAX   = 4096,
  parameter int FRAME_LINES_MAX = 2048,
  parameter int STRENGTH_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic                      cfg_rd,
  input  logic [2:0]                cfg_adr,
  input  logic [31:0]               cfg_di,
  output logic [31:0]               cfg_do,
  input  logic                      de_i,
  input  logic                      hs_i,
  input  logic                      vs_i,
  output logic                      bypass_o,
  output logic [STRENGTH_WIDTH-1:0] strength_o,
  output logic                      frame_done_o,
  output logic                      irq_o,
  output logic                      err_o
);
  localparam int PW = $clog2(LINE_SIZE_MAX + 1);
  localparam int LW = $clog2(FRAME_LINES_MAX + 1);
  state_t state, state_nxt;
  cfg_t shadow, sh_nxt;
  logic enable, irq, err_w, err_h, busy, wr_ctrl, irq_clr, err_clr;
  logic commit, close, fend, pix_clr, pix_en, w_bad, h_bad;
  logic line_end, line_start, frame_start, frame_end, pix_ovf, line_ovf;
  logic act_bypass;
  logic [STRENGTH_WIDTH-1:0] act_strength;
  logic [31:0] act_exp_w, act_exp_h, rd_val, fcnt_val;
  logic [PW-1:0] pix_cnt, meas_w;
  logic [LW-1:0] line_cnt, meas_h, h_val;
  video_sync_meas #(.LINE_SIZE_MAX(LINE_SIZE_MAX), .FRAME_LINES_MAX(FRAME_LINES_MAX)) u_meas (
    .clk(clk), .rst(rst), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .pix_en(pix_en), .pix_clr(pix_clr), .line_inc(close), .line_clr(fend),
    .line_end(line_end), .line_start(line_start), .frame_start(frame_start), .frame_end(frame_end),
    .pix_ovf(pix_ovf), .line_ovf(line_ovf), .pix_cnt(pix_cnt), .line_cnt(line_cnt)
  );
  assign wr_ctrl = cfg_wr && cfg_adr == ADR_CTRL;
  assign irq_clr = wr_ctrl && cfg_di[CTRL_IRQ_CLR];
  assign err_clr = wr_ctrl && cfg_di[CTRL_ERR_CLR];
  assign pix_en  = state == S_LINE;
  assign busy    = state == S_LINE || state == S_HBLANK || state == S_FEND;
  // A line closed by vs fall still counts toward the frame height reported in the same cycle.
  assign h_val   = (close && line_cnt != LW'(FRAME_LINES_MAX)) ? line_cnt + 1'b1 : line_cnt;
  assign w_bad   = (close && 32'(pix_cnt) != act_exp_w) || pix_ovf;
  assign h_bad   = (fend && 32'(h_val) != act_exp_h) || line_ovf;
  assign bypass_o   = act_bypass;
  assign strength_o = act_strength;
  assign irq_o      = irq;
  assign err_o      = err_w | err_h;
  always_comb begin
    sh_nxt          = shadow;
    sh_nxt.bypass   = wr_ctrl ? cfg_di[CTRL_BYPASS] : shadow.bypass;
    sh_nxt.strength = (cfg_wr && cfg_adr == ADR_STRENGTH) ? 8'(cfg_di[STRENGTH_WIDTH-1:0]) : shadow.strength;
    sh_nxt.exp_w    = (cfg_wr && cfg_adr == ADR_EXP_W) ? cfg_di : shadow.exp_w;
    sh_nxt.exp_h    = (cfg_wr && cfg_adr == ADR_EXP_H) ? cfg_di : shadow.exp_h;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    close     = 1'b0;
    fend      = 1'b0;
    pix_clr   = 1'b0;
    case (state)
      S_IDLE:    state_nxt = (enable && !vs_i) ? S_WAIT_VS : S_IDLE;
      S_WAIT_VS: begin
        commit    = enable && frame_start;
        state_nxt = !enable ? S_IDLE : frame_start ? S_LINE : S_WAIT_VS;
      end
      S_LINE: begin
        close     = line_end || frame_end;
        fend      = frame_end;
        pix_clr   = frame_end;
        state_nxt = frame_end ? (enable ? S_WAIT_VS : S_IDLE) : line_end ? S_HBLANK : S_LINE;
      end
      S_HBLANK: begin
        pix_clr   = line_start && !frame_end;
        state_nxt = frame_end ? S_FEND : line_start ? S_LINE : S_HBLANK;
      end
      S_FEND: begin
        fend      = 1'b1;
        pix_clr   = 1'b1;
        state_nxt = enable ? S_WAIT_VS : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    rd_val = '0;
    case (cfg_adr)
      ADR_CTRL:     rd_val = {30'd0, enable, shadow.bypass};
      ADR_STRENGTH: rd_val = {24'd0, shadow.strength};
      ADR_EXP_W:    rd_val = shadow.exp_w;
      ADR_EXP_H:    rd_val = shadow.exp_h;
      ADR_STATUS:   rd_val = {28'd0, busy, err_h, err_w, irq};
      ADR_MEAS:     rd_val = {16'(meas_h), 16'(meas_w)};
      ADR_FCNT:     rd_val = fcnt_val;
      default:      rd_val = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shadow       <= CFG_RST;
      enable       <= 1'b0;
      act_bypass   <= 1'b1;
      act_strength <= '0;
      act_exp_w    <= '0;
      act_exp_h    <= '0;
      meas_w       <= '0;
      meas_h       <= '0;
      irq          <= 1'b0;
      err_w        <= 1'b0;
      err_h        <= 1'b0;
      frame_done_o <= 1'b0;
      cfg_do       <= '0;
    end else begin
      shadow       <= sh_nxt;
      enable       <= wr_ctrl ? cfg_di[CTRL_ENABLE] : enable;
      act_bypass   <= commit ? sh_nxt.bypass : act_bypass;
      act_strength <= commit ? sh_nxt.strength[STRENGTH_WIDTH-1:0] : act_strength;
      act_exp_w    <= commit ? sh_nxt.exp_w : act_exp_w;
      act_exp_h    <= commit ? sh_nxt.exp_h : act_exp_h;
      meas_w       <= close ? pix_cnt : meas_w;
      meas_h       <= fend ? h_val : meas_h;
      irq          <= fend | (irq & ~irq_clr);
      err_w        <= w_bad | (err_w & ~err_clr);
      err_h        <= h_bad | (err_h & ~err_clr);
      frame_done_o <= fend;
      cfg_do       <= cfg_rd ? rd_val : cfg_do;
    end
`ifdef FILTER_SHARPENING_CTRL_FCNT_EN
  logic [31:0] fcnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) fcnt <= '0;
    else fcnt <= (wr_ctrl && cfg_di[CTRL_FCNT_CLR]) ? '0 : fend ? fcnt + 32'd1 : fcnt;
  assign fcnt_val = fcnt;
`else
  assign fcnt_val = '0;
`endif
endmodule

// File: tb/tb_filter_sharpening_ctrl.sv
// tb_filter_sharpening_ctrl: directed frames and register-table checks for filter_sharpening_ctrl
module tb_filter_sharpening_ctrl;
  logic clk = 0, rst = 0, cfg_wr = 0, cfg_rd = 0, de_i = 0, hs_i = 1, vs_i = 0;
  logic [2:0] cfg_adr = 0;
  logic [31:0] cfg_di = 0, cfg_do;
  logic bypass_o, frame_done_o, irq_o, err_o;
  logic [3:0] strength_o;
  int checks = 0, failures = 0, done_cnt = 0, d0 = 0;
  int hook_line = 0, hook_op = 0;
  logic b0, b1;
  logic [3:0] s1;
  logic [31:0] rv;

  typedef struct { logic [2:0] adr; logic [31:0] exp; string name; } rv_t;
  rv_t tbl [8];

  filter_sharpening_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_adr(cfg_adr),
    .cfg_di(cfg_di), .cfg_do(cfg_do), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .bypass_o(bypass_o), .strength_o(strength_o), .frame_done_o(frame_done_o),
    .irq_o(irq_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done_o) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_wr = 1; cfg_adr = a; cfg_di = d;
    cyc();
    cfg_wr = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cfg_rd = 1; cfg_adr = a;
    cyc();
    d = cfg_do;
    cfg_rd = 0;
  endtask

  task automatic hook();
    case (hook_op)
      1: begin wr(3'd1, 32'd9); chk("midwrite_hold", 32'(strength_o), 32'd5); end
      2: chk("err_w_after_line3", 32'(err_o), 32'd1);
      3: wr(3'd0, 32'h2);
      4: begin
        #2 rst = 0;
        #1 chk("async_rst_bypass", 32'(bypass_o), 32'd1);
        chk("async_rst_strength", 32'(strength_o), 32'd0);
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        cyc();
        rst = 1;
        wr(3'd2, 32'd24); wr(3'd3, 32'd24); wr(3'd1, 32'd7); wr(3'd0, 32'h2);
      end
      default: ;
    endcase
  endtask

  task automatic frame(input int lines, input int short_line);
    vs_i = 0; hs_i = 1; de_i = 0;
    repeat (4) cyc();
    vs_i = 1;
    cyc(); b0 = bypass_o;
    cyc(); b1 = bypass_o; s1 = strength_o;
    cyc();
    for (int l = 1; l <= lines; l++) begin
      hs_i = 0;
      if (l == hook_line) hook();
      cyc();
      for (int p = 0; p < ((l == short_line) ? 23 : 24); p++) begin
        de_i = 1; cyc();
        de_i = 0; cyc();
      end
      cyc();
      hs_i = 1;
      repeat (4) cyc();
    end
    vs_i = 0;
    repeat (6) cyc();
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset_bypass", 32'(bypass_o), 32'd1);
    chk("reset_strength", 32'(strength_o), 32'd0);
    chk("reset_irq", 32'(irq_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_done", 32'(frame_done_o), 32'd0);
    chk("reset_cfg_do", cfg_do, 32'd0);
    rst = 1;
    cyc();
    wr(3'd2, 32'd24); wr(3'd3, 32'd24); wr(3'd1, 32'd5); wr(3'd0, 32'h2);
    chk("pre_commit_bypass", 32'(bypass_o), 32'd1);
    d0 = done_cnt;
    frame(24, 0);
    chk("f1_bypass_before", 32'(b0), 32'd1);
    chk("f1_bypass_commit", 32'(b1), 32'd0);
    chk("f1_strength_commit", 32'(s1), 32'd5);
    chk("f1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("f1_err", 32'(err_o), 32'd0);
    chk("f1_irq", 32'(irq_o), 32'd1);
    tbl[0] = '{3'd0, 32'h2, "rd_ctrl"};
    tbl[1] = '{3'd1, 32'd5, "rd_strength"};
    tbl[2] = '{3'd2, 32'd24, "rd_exp_w"};
    tbl[3] = '{3'd3, 32'd24, "rd_exp_h"};
    tbl[4] = '{3'd4, 32'h1, "rd_status"};
    tbl[5] = '{3'd5, 32'h0018_0018, "rd_meas"};
`ifdef FILTER_SHARPENING_CTRL_FCNT_EN
    tbl[6] = '{3'd6, 32'd1, "rd_fcnt"};
`else
    tbl[6] = '{3'd6, 32'd0, "rd_fcnt"};
`endif
    tbl[7] = '{3'd7, 32'd0, "rd_unmapped"};
    for (int i = 0; i < 8; i++) begin
      rd(tbl[i].adr, rv);
      chk(tbl[i].name, rv, tbl[i].exp);
    end
    cyc();
    chk("cfg_do_hold", cfg_do, 32'd0);
    wr(3'd0, 32'h6);
    chk("irq_clr", 32'(irq_o), 32'd0);
    hook_line = 10; hook_op = 1;
    frame(24, 0);
    chk("midwrite_frame_end", 32'(strength_o), 32'd5);
    hook_line = 4; hook_op = 2;
    frame(24, 3);
    chk("next_frame_commit", 32'(s1), 32'd9);
    rd(3'd4, rv);
    chk("status_err_w", rv, 32'h3);
    wr(3'd0, 32'hA);
    chk("err_clr", 32'(err_o), 32'd0);
    chk("irq_kept", 32'(irq_o), 32'd1);
    hook_line = 0;
    frame(20, 0);
    chk("h_err", 32'(err_o), 32'd1);
    chk("h_irq", 32'(irq_o), 32'd1);
    rd(3'd5, rv);
    chk("h_meas", rv, 32'h0014_0018);
    rd(3'd4, rv);
    chk("h_status", rv, 32'h5);
    wr(3'd0, 32'h6);
    chk("h_irq_clr", 32'(irq_o), 32'd0);
    chk("h_err_held", 32'(err_o), 32'd1);
    wr(3'd0, 32'hA);
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd3);
    d0 = done_cnt;
    hook_line = 5; hook_op = 3;
    frame(24, 0);
    chk("late_en_no_done", 32'(done_cnt - d0), 32'd0);
    chk("late_en_no_commit", 32'(strength_o), 32'd9);
    hook_line = 0;
    d0 = done_cnt;
    frame(24, 0);
    chk("late_en_commit", 32'(s1), 32'd3);
    chk("late_en_done", 32'(done_cnt - d0), 32'd1);
    hook_line = 12; hook_op = 4;
    d0 = done_cnt;
    frame(24, 0);
    chk("post_rst_no_commit_s", 32'(strength_o), 32'd0);
    chk("post_rst_no_commit_b", 32'(bypass_o), 32'd1);
    chk("post_rst_no_done", 32'(done_cnt - d0), 32'd0);
    hook_line = 0;
    frame(24, 0);
    chk("post_rst_b0", 32'(b0), 32'd1);
    chk("post_rst_b1", 32'(b1), 32'd0);
    chk("post_rst_s1", 32'(s1), 32'd7);
    chk("post_rst_err", 32'(err_o), 32'd0);
    rd(3'd5, rv);
    chk("post_rst_meas", rv, 32'h0018_0018);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
